// File: rtl/vx_tensor_csr_pkg.sv
// vx_tensor_csr_pkg: bridge state encoding, CSR window offsets and CTRL/status bit positions.
package vx_tensor_csr_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_LD, S_WAIT_EX, S_WAIT_ST, S_STORE} state_t;
    localparam logic [1:0] GRP_A = 2'd0, GRP_B = 2'd1, GRP_C = 2'd2;
    localparam logic [3:0] OFF_CTRL = 4'd12, OFF_CYCLES = 4'd13;
    localparam int CTRL_START = 0, CTRL_CLR = 1;
    localparam int STAT_BUSY = 0, STAT_DONE = 1, STAT_ERR = 2;
endpackage

// File: rtl/vx_tensor_csr_tilebuf.sv
// vx_tensor_csr_tilebuf: NUM_ROWS x DATA_WIDTH row file, one write port, CSR and stream read ports.
module vx_tensor_csr_tilebuf #(
    parameter int NUM_ROWS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IW = $clog2(NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IW-1:0]         csr_addr,
    input  logic [IW-1:0]         stream_addr,
    output logic [DATA_WIDTH-1:0] csr_data,
    output logic [DATA_WIDTH-1:0] stream_data
);
    logic [DATA_WIDTH-1:0] rows [NUM_ROWS];

    always_ff @(posedge clk) begin
        if (!reset) rows <= '{default: '0};
        else if (we) rows[waddr] <= wdata;
    end

    assign csr_data = rows[csr_addr];
    assign stream_data = rows[stream_addr];
endmodule

// File: rtl/vx_tensor_csr_bridge.sv
// vx_tensor_csr_bridge: CSR-programmed initiator that streams A/B tiles to the tensor unit and collects C.
// Define VX_TENSOR_CSR_TIMEOUT_EN to add a watchdog that aborts stalled handshakes with ERR set.
module vx_tensor_csr_bridge
    import vx_tensor_csr_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int DATA_WIDTH = 32,
    parameter logic [11:0] CSR_BASE = 12'hCC0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_wr_valid,
    input  logic [11:0]           csr_wr_addr,
    input  logic [DATA_WIDTH-1:0] csr_wr_data,
    input  logic [11:0]           csr_rd_addr,
    output logic [DATA_WIDTH-1:0] csr_rd_data,
    output logic                  tensor_load_start,
    output logic [DATA_WIDTH-1:0] data_out_a,
    output logic [DATA_WIDTH-1:0] data_out_b,
    input  logic                  tensor_load_done,
    input  logic                  tensor_execute_done,
    input  logic                  tensor_store_start,
    input  logic                  tensor_store_done,
    input  logic [DATA_WIDTH-1:0] data_in_c,
    output logic                  busy,
    output logic                  done_irq
);
    localparam int IW = $clog2(NUM_ROWS);
    localparam logic [IW-1:0] LAST = IW'(NUM_ROWS - 1);

    state_t state;
    logic [IW-1:0] row, c_addr;
    logic [15:0] cycles;
    logic [11:0] wr_off, rd_off;
    logic [2:0] status;
    logic [DATA_WIDTH-1:0] a_csr, b_csr, c_csr, a_row, b_row, c_unused;
    logic c_full, ld_seen, ex_seen, ss_seen, sd_seen, done, err, timeout;
    logic wr_in, rd_in, ab_open, ctrl_wr, start, clr, ld, ex, ss, sd, last, c_we;

    assign wr_off = csr_wr_addr - CSR_BASE;
    assign rd_off = csr_rd_addr - CSR_BASE;
    assign wr_in = csr_wr_valid && wr_off < 12'd16;
    assign rd_in = rd_off < 12'd16;
    assign ab_open = wr_in && state == S_IDLE;
    assign ctrl_wr = wr_in && wr_off[3:0] == OFF_CTRL;
    assign start = ctrl_wr && csr_wr_data[CTRL_START];
    assign clr = ctrl_wr && csr_wr_data[CTRL_CLR];
    // handshake seen now or earlier in this operation
    assign ld = tensor_load_done || ld_seen;
    assign ex = tensor_execute_done || ex_seen;
    assign ss = tensor_store_start || ss_seen;
    assign sd = tensor_store_done || sd_seen;
    assign last = c_full || row == LAST;
    assign c_we = (state == S_WAIT_ST && ss) || (state == S_STORE && !c_full);
    assign c_addr = state == S_STORE ? row : '0;

    assign busy = state != S_IDLE;
    assign tensor_load_start = state == S_LOAD && row == '0;
    assign data_out_a = state == S_LOAD ? a_row : '0;
    assign data_out_b = state == S_LOAD ? b_row : '0;

    always_comb begin
        status = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done;
        status[STAT_ERR] = err;
    end

    assign csr_rd_data = !rd_in ? '0 :
                         rd_off[3:2] == GRP_A ? a_csr :
                         rd_off[3:2] == GRP_B ? b_csr :
                         rd_off[3:2] == GRP_C ? c_csr :
                         rd_off[3:0] == OFF_CTRL ? DATA_WIDTH'(status) :
                         rd_off[3:0] == OFF_CYCLES ? DATA_WIDTH'(cycles) : '0;

    vx_tensor_csr_tilebuf #(.NUM_ROWS(NUM_ROWS), .DATA_WIDTH(DATA_WIDTH)) u_a (
        .clk(clk), .reset(reset), .we(ab_open && wr_off[3:2] == GRP_A), .waddr(wr_off[IW-1:0]),
        .wdata(csr_wr_data), .csr_addr(rd_off[IW-1:0]), .stream_addr(row),
        .csr_data(a_csr), .stream_data(a_row));

    vx_tensor_csr_tilebuf #(.NUM_ROWS(NUM_ROWS), .DATA_WIDTH(DATA_WIDTH)) u_b (
        .clk(clk), .reset(reset), .we(ab_open && wr_off[3:2] == GRP_B), .waddr(wr_off[IW-1:0]),
        .wdata(csr_wr_data), .csr_addr(rd_off[IW-1:0]), .stream_addr(row),
        .csr_data(b_csr), .stream_data(b_row));

    vx_tensor_csr_tilebuf #(.NUM_ROWS(NUM_ROWS), .DATA_WIDTH(DATA_WIDTH)) u_c (
        .clk(clk), .reset(reset), .we(c_we), .waddr(c_addr),
        .wdata(data_in_c), .csr_addr(rd_off[IW-1:0]), .stream_addr(row),
        .csr_data(c_csr), .stream_data(c_unused));

`ifdef VX_TENSOR_CSR_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd;
    logic waiting, adv;
    assign waiting = state inside {S_WAIT_LD, S_WAIT_EX, S_WAIT_ST, S_STORE};
    assign adv = (state == S_WAIT_LD && ld) || (state == S_WAIT_EX && ex) ||
                 (state == S_WAIT_ST && ss) || (state == S_STORE && last && sd);
    assign timeout = waiting && !adv && wd == WW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) wd <= (!reset || !waiting || adv) ? '0 : wd + WW'(1);
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            row <= '0;
            c_full <= 1'b0;
            {ld_seen, ex_seen, ss_seen, sd_seen} <= '0;
            done <= 1'b0;
            err <= 1'b0;
            done_irq <= 1'b0;
            cycles <= '0;
        end else begin
            done_irq <= 1'b0;
            if (busy) begin
                {ld_seen, ex_seen, ss_seen, sd_seen} <= {ld, ex, ss, sd};
                cycles <= cycles == 16'hFFFF ? cycles : cycles + 16'd1;
                if (clr) err <= 1'b0;
            end else if (clr) begin
                done <= 1'b0;
                err <= 1'b0;
            end
            case (state)
                S_IDLE: if (start) begin
                    state <= S_LOAD;
                    row <= '0;
                    c_full <= 1'b0;
                    {ld_seen, ex_seen, ss_seen, sd_seen} <= '0;
                    done <= 1'b0;
                    err <= 1'b0;
                    cycles <= '0;
                end
                S_LOAD: if (row == LAST) begin
                    state <= S_WAIT_LD;
                    row <= '0;
                end else row <= row + IW'(1);
                S_WAIT_LD: if (ld) state <= S_WAIT_EX;
                S_WAIT_EX: if (ex) state <= S_WAIT_ST;
                S_WAIT_ST: if (ss) begin
                    state <= S_STORE;
                    row <= IW'(1);
                end
                S_STORE: begin
                    if (!c_full) begin
                        if (row == LAST) c_full <= 1'b1;
                        else row <= row + IW'(1);
                    end
                    if (last && sd) begin
                        state <= S_IDLE;
                        done <= 1'b1;
                        done_irq <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (timeout) begin
                state <= S_IDLE;
                done <= 1'b0;
                err <= 1'b1;
                done_irq <= 1'b1;
            end
        end
    end
endmodule
